// File: rtl/cart_loader.sv
// cart_loader: turns the HPS ioctl download stream into write cycles for the
// 4 KiB Studio II memory image, parsing ST2 headers and relocating data blocks.
module cart_loader #(
  parameter logic [7:0] RAW_INDEX = 8'd0,
  parameter logic [7:0] ST2_INDEX = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {S_IDLE, S_RAW, S_HDR, S_DATA, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        dl_p0;
  logic [7:0]  nblk_q;
  logic [7:0]  pt_q [16];

  logic        wr_d;
  logic [11:0] addr_d;
  logic        err_set, err_clr, done_d, nblk_we, pt_we;

  logic        dl_rise;
  logic        hi_bits;
  logic [7:0]  blk;
  logic [7:0]  page;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'h52;
      2'd1:    magic_byte = 8'h43;
      2'd2:    magic_byte = 8'h41;
      default: magic_byte = 8'h32;
    endcase
  endfunction

  // Rise detection needs history so a download held high across reset is ignored.
  assign dl_rise = ioctl_download & ~dl_p0;
  assign hi_bits = |ioctl_addr[24:16];
  assign blk     = ioctl_addr[15:8] - 8'd1;
  assign page    = pt_q[blk[3:0]];

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    addr_d  = ioctl_addr[11:0];
    err_set = 1'b0;
    err_clr = 1'b0;
    done_d  = 1'b0;
    nblk_we = 1'b0;
    pt_we   = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (dl_rise) begin
          if (ioctl_index == RAW_INDEX) begin
            state_d = S_RAW;
            err_clr = 1'b1;
          end else if (ioctl_index == ST2_INDEX) begin
            state_d = S_HDR;
            err_clr = 1'b1;
          end
        end
      end
      S_RAW: begin
        if (ioctl_wr && ioctl_addr[24:12] == 13'd0) wr_d = 1'b1;
        if (!ioctl_download) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_HDR: begin
        if (ioctl_wr) begin
          if (hi_bits) begin
            err_set = 1'b1;
          end else if (ioctl_addr[15:8] == 8'd0) begin
            if (ioctl_addr[7:2] == 6'd0) begin
              if (ioctl_data != magic_byte(ioctl_addr[1:0])) state_d = S_ERR;
            end else if (ioctl_addr[7:0] == 8'd4) begin
              nblk_we = 1'b1;
              if (ioctl_data == 8'd0 || ioctl_data > 8'd17) state_d = S_ERR;
            end else if (ioctl_addr[7:4] == 4'h4) begin
              pt_we = 1'b1;
            end else if (ioctl_addr[7:0] == 8'hFF) begin
              state_d = S_DATA;
            end
          end
        end
        // A header completed by the final byte still counts as a finished load.
        if (!ioctl_download) begin
          if (state_d == S_DATA) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (ioctl_wr) begin
          if (hi_bits) begin
            err_set = 1'b1;
          end else if (blk < nblk_q - 8'd1) begin
            if (page[7:4] != 4'h0) begin
              err_set = 1'b1;
            end else begin
              wr_d   = 1'b1;
              addr_d = {page[3:0], ioctl_addr[7:0]};
            end
          end
        end
        if (!ioctl_download) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: write port, status outputs and header tables.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dl_p0      <= ioctl_download;
      mem_we     <= 1'b0;
      mem_addr   <= 12'd0;
      mem_data   <= 8'd0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      nblk_q     <= 8'd0;
      for (int i = 0; i < 16; i++) pt_q[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      dl_p0      <= ioctl_download;
      mem_we     <= wr_d;
      if (wr_d) begin
        mem_addr <= addr_d;
        mem_data <= ioctl_data;
      end
      cpu_hold   <= (state_d != S_IDLE);
      load_done  <= done_d;
      load_error <= (state_d == S_ERR) | err_set | (load_error & ~err_clr);
      if (nblk_we) nblk_q <= ioctl_data;
      if (pt_we) pt_q[ioctl_addr[3:0]] <= ioctl_data;
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Testbench for cart_loader: table-driven load scenarios, hand-written timing
// sequences and randomized loads against a file-level reference model.
module tb_cart_loader;

  localparam logic [7:0] RAW_IDX = 8'd0;
  localparam logic [7:0] ST2_IDX = 8'd1;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  always #5 clk_sys = ~clk_sys;

  cart_loader #(.RAW_INDEX(RAW_IDX), .ST2_INDEX(ST2_IDX)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  file_mem [0:8191];
  logic [19:0] got_q [$];
  logic [19:0] exp_q [$];
  int          done_cnt = 0;
  int          hold_low = 0;
  bit          hold_chk = 1'b0;
  bit          m_err = 1'b0, m_in_err = 1'b0;
  bit          exp_err, exp_done, exp_hold;

  typedef struct {
    logic [7:0] idx;
    int         n;
    logic [7:0] m2;
    logic [7:0] nblk;
    logic [7:0] pt0;
    logic [7:0] pt1;
    bit         fall_wr;
    int         exp_wr;
    bit         e_err;
    bit         e_done;
    bit         e_hold;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (mem_we) got_q.push_back({mem_addr, mem_data});
    if (load_done) done_cnt++;
    if (hold_chk && !cpu_hold) hold_low++;
  endtask

  task automatic build_raw(input int n);
    for (int i = 0; i < n; i++) file_mem[i] = 8'(i) ^ 8'h5A;
  endtask

  task automatic build_st2(input logic [7:0] m2, input logic [7:0] nblk,
                           input logic [7:0] pt0, input logic [7:0] pt1, input int n);
    for (int i = 0; i < n; i++) file_mem[i] = 8'(i) ^ 8'h5A;
    file_mem[0] = 8'h52; file_mem[1] = 8'h43; file_mem[2] = m2; file_mem[3] = 8'h32;
    file_mem[4] = nblk;
    file_mem[64] = pt0; file_mem[65] = pt1;
    for (int k = 2; k < 16; k++) file_mem[64 + k] = 8'(k);
  endtask

  // File-level model: derives the write list and final status from the image.
  task automatic model_load(input logic [7:0] idx, input int n);
    logic [7:0] magic [4];
    bit         bad;
    int         nb, b;
    logic [7:0] p;
    magic = '{8'h52, 8'h43, 8'h41, 8'h32};
    exp_q.delete();
    exp_done = 1'b0;
    bad = 1'b0;
    if (idx == RAW_IDX) begin
      for (int i = 0; i < n && i < 4096; i++) exp_q.push_back({12'(i), file_mem[i]});
      m_err = 1'b0; m_in_err = 1'b0; exp_done = 1'b1;
    end else if (idx == ST2_IDX) begin
      m_err = 1'b0;
      for (int i = 0; i < 4 && i < n; i++) if (file_mem[i] != magic[i]) bad = 1'b1;
      nb = int'(file_mem[4]);
      if (n > 4 && (nb == 0 || nb > 17)) bad = 1'b1;
      if (n < 256) bad = 1'b1;
      if (bad) begin
        m_err = 1'b1; m_in_err = 1'b1;
      end else begin
        for (int a = 256; a < n; a++) begin
          b = a / 256 - 1;
          if (b < nb - 1) begin
            p = file_mem[64 + b];
            if (p[7:4] != 4'h0) m_err = 1'b1;
            else exp_q.push_back({p[3:0], 8'(a), file_mem[a]});
          end
        end
        exp_done = 1'b1; m_in_err = 1'b0;
      end
    end
    exp_err = m_err;
    exp_hold = m_in_err;
  endtask

  task automatic send_file(input logic [7:0] idx, input int n, input bit gaps, input bit fall_wr);
    got_q.delete(); done_cnt = 0; hold_low = 0;
    ioctl_index = idx; ioctl_download = 1'b1;
    tick();
    hold_chk = (idx == RAW_IDX || idx == ST2_IDX);
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = file_mem[i];
      if (fall_wr && i == n - 1) begin
        ioctl_download = 1'b0; hold_chk = 1'b0;
      end
      tick();
      ioctl_wr = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
    hold_chk = 1'b0; ioctl_download = 1'b0;
    repeat (4) tick();
  endtask

  task automatic compare_load(input string tag, input int exp_wr, input bit e_err,
                              input bit e_done, input bit e_hold);
    int mism, first;
    mism = 0; first = -1;
    check({tag, " write_count"}, got_q.size(), exp_wr);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    check({tag, " write_mismatches"}, mism, 0);
    if (first >= 0)
      $display("  %s first differing write #%0d: got %05h expected %05h", tag, first, got_q[first], exp_q[first]);
    check({tag, " done_pulses"}, done_cnt, e_done);
    check({tag, " load_error"}, load_error, e_err);
    check({tag, " cpu_hold_after"}, cpu_hold, e_hold);
    check({tag, " cpu_hold_dropouts"}, hold_low, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.idx == ST2_IDX) build_st2(v.m2, v.nblk, v.pt0, v.pt1, v.n);
    else build_raw(v.n);
    model_load(v.idx, v.n);
    send_file(v.idx, v.n, 1'b0, v.fall_wr);
    compare_load(tag, v.exp_wr, v.e_err, v.e_done, v.e_hold);
  endtask

  initial begin
    tbl[0]  = '{RAW_IDX, 2048, 8'h41, 8'd0,  8'h00, 8'h00, 1'b0, 2048, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{RAW_IDX, 4100, 8'h41, 8'd0,  8'h00, 8'h00, 1'b0, 4096, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{ST2_IDX, 768,  8'h41, 8'd3,  8'h04, 8'h0A, 1'b0, 512,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{ST2_IDX, 768,  8'h42, 8'd3,  8'h04, 8'h0A, 1'b0, 0,    1'b1, 1'b0, 1'b1};
    tbl[4]  = '{RAW_IDX, 16,   8'h41, 8'd0,  8'h00, 8'h00, 1'b1, 16,   1'b0, 1'b1, 1'b0};
    tbl[5]  = '{ST2_IDX, 768,  8'h41, 8'd3,  8'h04, 8'h1C, 1'b0, 256,  1'b1, 1'b1, 1'b0};
    tbl[6]  = '{RAW_IDX, 8,    8'h41, 8'd0,  8'h00, 8'h00, 1'b0, 8,    1'b0, 1'b1, 1'b0};
    tbl[7]  = '{ST2_IDX, 300,  8'h41, 8'd0,  8'h04, 8'h0A, 1'b0, 0,    1'b1, 1'b0, 1'b1};
    tbl[8]  = '{8'h07,   20,   8'h41, 8'd0,  8'h00, 8'h00, 1'b0, 0,    1'b1, 1'b0, 1'b1};
    tbl[9]  = '{ST2_IDX, 300,  8'h41, 8'd18, 8'h04, 8'h0A, 1'b0, 0,    1'b1, 1'b0, 1'b1};
    tbl[10] = '{ST2_IDX, 100,  8'h41, 8'd3,  8'h04, 8'h0A, 1'b0, 0,    1'b1, 1'b0, 1'b1};
    tbl[11] = '{ST2_IDX, 768,  8'h41, 8'd2,  8'h04, 8'h0A, 1'b1, 256,  1'b0, 1'b1, 1'b0};
    tbl[12] = '{ST2_IDX, 4362, 8'h41, 8'd17, 8'h00, 8'h01, 1'b0, 4096, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{8'h07,   20,   8'h41, 8'd0,  8'h00, 8'h00, 1'b0, 0,    1'b0, 1'b0, 1'b0};

    repeat (3) tick();
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_data", mem_data, 0);
    check("reset cpu_hold", cpu_hold, 0);
    check("reset load_done", load_done, 0);
    check("reset load_error", load_error, 0);
    reset = 1'b0;
    tick();

    // Single-byte RAW load: hold rise, write latency, data hold, done timing.
    got_q.delete(); done_cnt = 0;
    ioctl_index = RAW_IDX; ioctl_download = 1'b1;
    tick();
    check("lat cpu_hold_rise", cpu_hold, 1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h123; ioctl_data = 8'hA5;
    tick();
    ioctl_wr = 1'b0;
    check("lat mem_we", mem_we, 1);
    check("lat mem_addr", mem_addr, 12'h123);
    check("lat mem_data", mem_data, 8'hA5);
    tick();
    check("lat we_one_cycle", mem_we, 0);
    check("lat addr_held", mem_addr, 12'h123);
    ioctl_download = 1'b0;
    tick();
    check("lat load_done", load_done, 1);
    check("lat cpu_hold_fall", cpu_hold, 0);
    tick();
    check("lat done_single", load_done, 0);
    m_err = 1'b0; m_in_err = 1'b0;

    // Reset after 100 data bytes of a valid ST2 load.
    build_st2(8'h41, 8'd3, 8'h04, 8'h0A, 768);
    got_q.delete(); done_cnt = 0;
    ioctl_index = ST2_IDX; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 356; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = file_mem[i];
      tick();
    end
    reset = 1'b1; ioctl_addr = 25'd356; ioctl_data = file_mem[356];
    tick();
    reset = 1'b0;
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_data", mem_data, 0);
    check("rst cpu_hold", cpu_hold, 0);
    check("rst load_done", load_done, 0);
    check("rst load_error", load_error, 0);
    for (int i = 357; i < 768; i++) begin
      ioctl_addr = 25'(i); ioctl_data = file_mem[i];
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (4) tick();
    check("rst write_count", got_q.size(), 100);
    check("rst done_pulses", done_cnt, 0);
    check("rst cpu_hold_after", cpu_hold, 0);
    m_err = 1'b0; m_in_err = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      logic [7:0] idx;
      int         n, sel;
      sel = int'($urandom_range(0, 4));
      idx = (sel == 0) ? RAW_IDX : (sel == 4) ? 8'h09 : ST2_IDX;
      if (idx == ST2_IDX) begin
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 255)) : 256 + int'($urandom_range(0, 1500));
        for (int i = 0; i < n; i++) file_mem[i] = 8'($urandom);
        file_mem[0] = 8'h52; file_mem[1] = 8'h43; file_mem[2] = 8'h41; file_mem[3] = 8'h32;
        if ($urandom_range(0, 7) == 0) file_mem[$urandom_range(0, 3)] ^= 8'h10;
        file_mem[4] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 19)) : 8'($urandom_range(1, 17));
        for (int k = 0; k < 16; k++)
          file_mem[64 + k] = {($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 4'($urandom)};
      end else begin
        n = (idx == RAW_IDX) ? int'($urandom_range(1, 1500)) : int'($urandom_range(1, 50));
        for (int i = 0; i < n; i++) file_mem[i] = 8'($urandom);
      end
      model_load(idx, n);
      send_file(idx, n, 1'b1, 1'($urandom_range(0, 1)));
      compare_load($sformatf("rnd%0d", r), exp_q.size(), exp_err, exp_done, exp_hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
# cart_loader

Consumes the HPS `ioctl` download byte stream on the core side and turns it into write cycles for the Studio II 4 KiB memory image. Raw images (boot ROM) are written linearly. ST2 cartridge images are parsed: header checked, page table captured, each 256-byte data block relocated to its page. Sits between `hps_io` and the `rcastudioii` memory, and holds the machine in reset while a load is in progress.

## Interface
Parameters:
- `RAW_INDEX`, 8'd0 — `ioctl_index` value selecting a raw linear image.
- `ST2_INDEX`, 8'd1 — `ioctl_index` value selecting an ST2 cartridge image.

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  high for the whole duration of a transfer.
- `ioctl_index`  in  8  image type; sampled on the `ioctl_download` rising edge.
- `ioctl_wr`  in  1  one-cycle strobe; byte valid.
- `ioctl_addr`  in  25  byte offset within the file.
- `ioctl_data`  in  8  byte value.
- `mem_addr`  out  12  target address.
- `mem_data`  out  8  write data.
- `mem_we`  out  1  one-cycle write strobe.
- `cpu_hold`  out  1  keeps the CPU in reset.
- `load_done`  out  1  one-cycle pulse on successful completion.
- `load_error`  out  1  sticky error flag; cleared at the next download start.

## Operation
States: IDLE, RAW, HDR, DATA, ERR.
- IDLE: waits for `ioctl_download` to rise.
  - Index equal to `RAW_INDEX` → RAW.
  - Index equal to `ST2_INDEX` → HDR.
  - Any other index → stays IDLE. The stream is ignored, `cpu_hold` stays 0, and nothing is written.
- Entering RAW or HDR clears `load_error` and asserts `cpu_hold`.
- RAW: each `ioctl_wr` with `ioctl_addr < 4096` writes `ioctl_data` to `ioctl_addr[11:0]`. Bytes at 4096 or above are dropped without error.
- HDR: covers offsets 0–255. No memory writes occur.
  - Bytes 0–3 must equal 0x52, 0x43, 0x41, 0x32 ("RCA2"). Any mismatch → ERR immediately.
  - Byte 4 is latched as `nblk`, the total block count including the header. `nblk == 0` or `nblk > 17` → ERR when byte 4 arrives.
  - Bytes 64–79 are latched into a 16-entry page table, `pt[0..15]`. All other header bytes are ignored.
  - After byte 255 is accepted → DATA.
- DATA: for the byte at file offset A, block b = A[15:8] − 1 and offset o = A[7:0].
  - If b ≥ nblk − 1, the byte is dropped (trailing data).
  - If pt[b][7:4] ≠ 0, the byte is dropped and `load_error` is set, but the state remains DATA.
  - Otherwise write `ioctl_data` to {pt[b][3:0], o}.
- `ioctl_download` falling:
  - From RAW or DATA → IDLE, `load_done` pulses, and `load_error` keeps its value.
  - From HDR (truncated header) → ERR.
- ERR: `load_error` = 1, no writes, `cpu_hold` stays 1. On the next `ioctl_download` rise, behaves as IDLE does.
- `ioctl_addr` bits 24:16 nonzero in ST2 mode → byte dropped, `load_error` set.
- Offsets are taken from `ioctl_addr`, not an internal counter. Skipped or repeated addresses are therefore honoured as given.

## Timing
- Reset: state IDLE; `mem_addr`=0, `mem_data`=0, `mem_we`=0, `cpu_hold`=0, `load_done`=0, `load_error`=0; page table and `nblk` cleared.
- Write latency: `mem_we`/`mem_addr`/`mem_data` are registered and valid exactly 1 cycle after the accepted `ioctl_wr` cycle. Data is held until the next write.
- `ioctl_wr` may be asserted on consecutive cycles. Every strobe is processed, with no backpressure.
- A page-table byte latched in HDR is usable by the first DATA byte, which arrives 1 cycle later at the earliest.
- `cpu_hold`:
  - Rises 1 cycle after the `ioctl_download` rise when the index matches.
  - Falls in the same cycle as the `load_done` pulse, which is 1 cycle after the `ioctl_download` fall, and no earlier than the cycle of the last `mem_we`.
  - In ERR it stays 1 until the next accepted download completes or `reset` is asserted.
- `ioctl_wr` in the same cycle as the `ioctl_download` fall: the byte is processed first, then completion follows.
- `reset` mid-transfer: immediate return to IDLE with all outputs at reset values. The rest of that transfer is ignored until `ioctl_download` falls and rises again.

## Test plan
- RAW load: index 0, 2048 bytes of value (addr ^ 0x5A) sent back to back → 2048 writes at addresses 0x000–0x7FF with matching data; one `load_done` pulse; `load_error` = 0.
- RAW overflow: index 0, 4100 bytes → exactly 4096 writes; the last write is at 0xFFF; no error.
- ST2 valid file:
  - Header: "RCA2", nblk = 3, pt[0] = 0x04, pt[1] = 0x0A.
  - Then 512 data bytes.
  - → Writes to 0x400–0x4FF, then 0xA00–0xAFF. No writes during the header. `load_done` pulses; `cpu_hold` is high throughout.
- ST2 bad magic: byte 2 = 0x42 → ERR; zero writes; `load_error` = 1 after the fall; `cpu_hold` stays 1; a following valid RAW load clears both.
- ST2 bad page: pt[1] = 0x1C with nblk = 3 → block 0 is written; all block 1 bytes are dropped; `load_error` = 1; `load_done` still pulses.
- Reset mid-DATA: `reset` asserted after 100 data bytes → outputs go to reset values on the next cycle; the remaining bytes produce no writes; the next download behaves normally.
